// File: rtl/fsm_step_pkg.sv
// rtl/fsm_step_pkg.sv - shared state encoding for the step controller
package fsm_step_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } step_state_t;

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - divide-by-DIV tick generator, held at 0 while not running
module step_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/fsm_step_controller.sv
// rtl/fsm_step_controller.sv - run/burst enable-pulse sequencer; STEP_CTRL_MANUAL_STEP_EN adds manual step in IDLE
module fsm_step_controller
    import fsm_step_pkg::*;
#(
    parameter int DIV = 4,
    parameter int BW  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               step,
    input  logic [BW-1:0]      burst_len,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    step_state_t   state_q, state_d;
    logic [BW-1:0] remaining_q, remaining_d;
    logic          tick;
    logic          en_auto;
    logic          en_manual;

    assign busy    = (state_q == RUN) || (state_q == BURST);
    assign done    = (state_q == DONE);
    assign state   = state_q;
    assign en_auto = busy && tick && !stop;

    step_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clear(stop),
        .run  (busy),
        .tick (tick)
    );

`ifdef STEP_CTRL_MANUAL_STEP_EN
    assign en_manual = (state_q == IDLE) && step && !stop && !start;
`else
    logic unused_step;
    assign unused_step = step;
    assign en_manual   = 1'b0;
`endif

    assign en = en_auto || en_manual;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (!stop && start) begin
                    if (burst_len == '0) begin
                        state_d = RUN;
                    end else begin
                        state_d     = BURST;
                        remaining_d = burst_len;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                if (stop) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (en_auto) begin
                    // the final step leaves BURST, so the counter never passes below zero
                    if (remaining_q <= BW'(1)) begin
                        state_d     = DONE;
                        remaining_d = '0;
                    end else begin
                        remaining_d = remaining_q - BW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                remaining_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fsm_step_controller.sv
// tb/tb_fsm_step_controller.sv - directed self-checking bench for fsm_step_controller
module tb_fsm_step_controller;

    localparam int DIV = 4;
    localparam int BW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          step;
    logic [BW-1:0] burst_len;
    logic          en;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [63:0] ev;
    logic [63:0] dv;
    logic [63:0] exp_ev;

    always #5 clk = ~clk;

    fsm_step_controller #(
        .DIV(DIV),
        .BW (BW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .step     (step),
        .burst_len(burst_len),
        .en       (en),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [BW-1:0] len);
        burst_len = len;
        start     = 1'b1;
        next_cycle();
        start     = 1'b0;
    endtask

    // cycle 1 is the first cycle spent in the new state; ms/ss pulse start/stop in that cycle
    task automatic run_cycles(input int n, input int ms, input int ss,
                              output logic [63:0] e, output logic [63:0] d);
        e = '0;
        d = '0;
        for (int c = 1; c <= n; c++) begin
            start = (c == ms);
            if (c == ms) burst_len = 4'd7;
            stop = (c == ss);
            #1;
            e[c-1] = en;
            d[c-1] = done;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; burst_len = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
        check("reset_en", en, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_state", state, 0);

        start_cmd(4'd0);
        check("run_state", state, 1);
        check("run_busy", busy, 1);
        run_cycles(16, -1, 16, ev, dv);
        check("run_en_pattern", ev, 64'h0888);
        check("run_stop_state", state, 0);
        check("run_stop_busy", busy, 0);

        start_cmd(4'd3);
        check("burst3_state", state, 2);
        run_cycles(16, -1, -1, ev, dv);
        check("burst3_en", ev, 64'h0888);
        check("burst3_done", dv, 64'h1000);
        check("burst3_idle", state, 0);

        start_cmd(4'd5);
        run_cycles(10, -1, 9, ev, dv);
        check("abort_en", ev, 64'h88);
        check("abort_done", dv, 0);
        check("abort_state", state, 0);
        start_cmd(4'd5);
        run_cycles(24, -1, -1, ev, dv);
        check("restart_en", ev, 64'h88888);
        check("restart_done", dv, 64'h100000);

        start_cmd(4'd3);
        run_cycles(16, 5, -1, ev, dv);
        check("midstart_en", ev, 64'h0888);
        check("midstart_done", dv, 64'h1000);

        start_cmd(4'd5);
        run_cycles(6, -1, -1, ev, dv);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        check("midreset_state", state, 0);
        check("midreset_busy", busy, 0);
        check("midreset_en", en, 0);
        start_cmd(4'd1);
        run_cycles(8, -1, -1, ev, dv);
        check("burst1_en", ev, 64'h8);
        check("burst1_done", dv, 64'h10);

        exp_ev = '0;
        for (int k = 1; k <= 15; k++) exp_ev[4*k-1] = 1'b1;
        start_cmd(4'hF);
        run_cycles(64, -1, -1, ev, dv);
        check("burst15_en", ev, exp_ev);
        check("burst15_done", dv, 64'h1 << 60);

        step = 1'b1;
        #1;
`ifdef STEP_CTRL_MANUAL_STEP_EN
        check("step_en", en, 1);
`else
        check("step_en", en, 0);
`endif
        check("step_state", state, 0);
        next_cycle();
        step = 1'b0;
        #1;
        check("step_en_after", en, 0);
        check("step_state_after", state, 0);

        step = 1'b1;
        burst_len = 4'd0;
        start = 1'b1;
        #1;
        check("step_vs_start_en", en, 0);
        next_cycle();
        start = 1'b0;
        #1;
        check("step_vs_start_state", state, 1);
        check("step_in_run_en", en, 0);
        step = 1'b0;
        stop = 1'b1;
        next_cycle();
        stop = 1'b0;
        #1;
        check("final_state", state, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fsm_step_controller.md
FSM_STEP_CONTROLLER -- requirements
Module: fsm_step_controller

Interface
REQ-001 Parameter DIV, default 4, is the number of clk cycles per enable pulse while running (legal range 2..256).
REQ-002 Parameter BW, default 4, is the width of burst_len and of the internal remaining-step counter.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-005 start  input  1  is a one-cycle request to begin stepping.
REQ-006 stop  input  1  is a request to abort stepping and return to IDLE.
REQ-007 step  input  1  is a request for a single manual enable pulse (see REQ-028).
REQ-008 burst_len  input  BW  gives the step count, where 0 means continuous run; it is sampled only when start is accepted.
REQ-009 en  output  1  is the enable pulse for the downstream fsm_arbitrary_counter, one clk wide per step.
REQ-010 busy  output  1  is high in RUN or BURST.
REQ-011 done  output  1  is a one-cycle pulse when a burst completes normally.
REQ-012 state  output  2  is the current state encoding, for debug and LEDs.

Function
REQ-013 The states SHALL be IDLE=0, RUN=1, BURST=2 and DONE=3.
REQ-014 In IDLE, start with burst_len==0 SHALL go to RUN, and start with burst_len!=0 SHALL go to BURST and load remaining=burst_len.
REQ-015 Input priority SHALL be reset > stop > start > step in every state.
REQ-016 start while busy or in DONE SHALL be ignored, with no reload of remaining.
REQ-017 The prescaler SHALL count 0..DIV-1 only in RUN and BURST, wrap to 0 after DIV-1, and be held at 0 in IDLE and DONE.
REQ-018 The combinational output en SHALL equal (state is RUN or BURST) AND (prescaler==DIV-1) AND ~stop.
REQ-019 The first en after entering RUN or BURST SHALL occur DIV cycles after the state change, and every subsequent en SHALL follow exactly DIV cycles later.
REQ-020 In RUN, stop SHALL go to IDLE at the next edge, and en SHALL be suppressed in the cycle stop is high.
REQ-021 In BURST, each en SHALL decrement remaining by 1.
REQ-022 In BURST, en with remaining==1 SHALL transition to DONE, so exactly burst_len en pulses occur.
REQ-023 In BURST, stop SHALL go to IDLE without asserting done, and remaining SHALL be cleared to 0.
REQ-024 DONE SHALL assert done=1 for exactly one cycle and then unconditionally return to IDLE.
REQ-025 busy SHALL be high iff state is RUN or BURST; done SHALL be high iff state is DONE.
REQ-026 The remaining counter SHALL never wrap below 0; a burst_len of all-ones SHALL yield 2^BW-1 steps.

Reset
REQ-027 While reset is high at a clk edge, the block SHALL set state=IDLE, prescaler=0 and remaining=0, giving en=0, busy=0, done=0 and state=0 in the following cycle, including when reset arrives mid-burst.

Configuration
REQ-028 With STEP_CTRL_MANUAL_STEP_EN defined, step in IDLE (with stop=0 and start=0) SHALL drive en=1 combinationally for that cycle while state stays IDLE, and step in any other state SHALL be ignored.
REQ-029 Without STEP_CTRL_MANUAL_STEP_EN, the step port SHALL remain present but be ignored, and en SHALL never assert in IDLE.

Structure
REQ-030 The state encoding constants (IDLE, RUN, BURST, DONE) and the state width SHALL reside in the shared package fsm_step_pkg.
REQ-031 The prescaler SHALL be a separate sub-module step_prescaler (parameter DIV; inputs clk, reset, clear, run; output tick), instantiated once.

Verification
REQ-032 The bench SHALL apply reset=1 for 2 cycles and then release it -> en=0, busy=0, done=0, state=0.
REQ-033 The bench SHALL apply DIV=4, start with burst_len=0 -> state=1, en pulses at 4, 8 and 12 cycles after entry; then stop -> IDLE next cycle with no en in the stop cycle.
REQ-034 The bench SHALL apply DIV=4, start with burst_len=3 -> exactly 3 en pulses 4 cycles apart, done=1 for one cycle after the third pulse, then state=0.
REQ-035 The bench SHALL apply burst_len=5 with stop after the 2nd en -> IDLE, done never asserts, and a second start is accepted with a fresh burst of 5.
REQ-036 The bench SHALL apply start mid-burst (burst_len changed to 7) -> ignored, and the original count completes.
REQ-037 The bench SHALL apply step in IDLE with the macro defined -> en=1 for exactly 1 cycle; with the macro undefined -> en stays 0.
